// File: rtl/cmd_frame_decode.sv
// cmd_frame_decode: parses UART byte frames into write-FIFO pushes and SDRAM
// write/read triggers.
//
// A frame is one command byte. WR_CMD is followed by PAYLOAD_LEN payload bytes,
// which are pushed into the write FIFO. RD_CMD stands alone. Any other byte in
// IDLE is reported on frame_err.
//
// Optional build macro CMD_FRAME_CHKSUM_EN:
//   When defined, a write frame ends with one checksum byte. That byte must equal
//   the XOR of the payload bytes before wr_trig is issued.
//   When undefined, wr_trig follows the last payload push.
//
// Valid/ready semantics: there is no backpressure on the input side.
// - uart_flag is a one-cycle strobe and uart_data is valid only in that cycle.
// - wfifo_full is sampled only in the cycle a payload byte arrives. A full FIFO
//   aborts the frame instead of stalling it.
// - Every output is registered. A response appears one cycle after the byte that
//   caused it. The exception is wr_trig without the checksum, which appears one
//   cycle after the last push.
module cmd_frame_decode #(
  parameter int         PAYLOAD_LEN = 4,
  parameter logic [7:0] WR_CMD      = 8'h55,
  parameter logic [7:0] RD_CMD      = 8'hAA,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_flag,
  input  logic [7:0] uart_data,
  input  logic       wfifo_full,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_data,
  output logic       wfifo_clr,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(PAYLOAD_LEN + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_LEN - 1);
  // to_q counts cycles since the last byte strobe, so expiry is checked one
  // cycle early. The registered error then lands exactly TIMEOUT_CYC cycles
  // after that strobe.
  localparam logic [TW-1:0] TO_LIMIT = TO_EN ? TW'(TIMEOUT_CYC - 1) : '0;

  // WR_DONE is a one-cycle gap so that wr_trig trails the last FIFO push.
  // A strobe in that single cycle is dropped: the UART cannot deliver bytes
  // that closely together.
`ifdef CMD_FRAME_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, WR_DATA, WR_DONE, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR_DATA, WR_DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
`ifdef CMD_FRAME_CHKSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  logic       wr_en_d;
  logic [7:0] data_d;
  logic       clr_d;
  logic       wr_trig_d;
  logic       rd_trig_d;
  logic       err_d;
  logic       busy_d;
  logic       timed_out;

  // Timeout expires when no strobe arrives in the last allowed cycle.
  assign timed_out = TO_EN && (to_q >= TO_LIMIT);

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
`ifdef CMD_FRAME_CHKSUM_EN
    xor_d     = xor_q;
`endif
    wr_en_d   = 1'b0;
    data_d    = 8'h00;
    clr_d     = 1'b0;
    wr_trig_d = 1'b0;
    rd_trig_d = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        to_d = '0;
        if (uart_flag) begin
          if (uart_data == RD_CMD) begin
            rd_trig_d = 1'b1;
          end else if (uart_data == WR_CMD) begin
            state_d = WR_DATA;
            cnt_d   = '0;
            to_d    = TW'(1);
`ifdef CMD_FRAME_CHKSUM_EN
            xor_d   = 8'h00;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      WR_DATA: begin
        // A byte arriving in the same cycle as timeout expiry is still accepted.
        if (uart_flag) begin
          to_d = TW'(1);
          if (wfifo_full) begin
            err_d   = 1'b1;
            clr_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wr_en_d = 1'b1;
            data_d  = uart_data;
            cnt_d   = cnt_q + CW'(1);
`ifdef CMD_FRAME_CHKSUM_EN
            xor_d   = xor_q ^ uart_data;
            if (cnt_q == LAST_IDX) state_d = CHK;
`else
            if (cnt_q == LAST_IDX) state_d = WR_DONE;
`endif
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          clr_d   = 1'b1;
          state_d = IDLE;
        end else if (TO_EN) begin
          to_d = to_q + TW'(1);
        end
      end

      WR_DONE: begin
        wr_trig_d = 1'b1;
        state_d   = IDLE;
        to_d      = '0;
      end

`ifdef CMD_FRAME_CHKSUM_EN
      CHK: begin
        // The checksum byte is compared against the payload XOR and is never pushed.
        if (uart_flag) begin
          to_d    = TW'(1);
          state_d = IDLE;
          if (uart_data == xor_q) begin
            wr_trig_d = 1'b1;
          end else begin
            err_d = 1'b1;
            clr_d = 1'b1;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          clr_d   = 1'b1;
          state_d = IDLE;
        end else if (TO_EN) begin
          to_d = to_q + TW'(1);
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs. Reset drops any open frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
`ifdef CMD_FRAME_CHKSUM_EN
      xor_q       <= 8'h00;
`endif
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= 8'h00;
      wfifo_clr   <= 1'b0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
`ifdef CMD_FRAME_CHKSUM_EN
      xor_q       <= xor_d;
`endif
      wfifo_wr_en <= wr_en_d;
      wfifo_data  <= data_d;
      wfifo_clr   <= clr_d;
      wr_trig     <= wr_trig_d;
      rd_trig     <= rd_trig_d;
      frame_err   <= err_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_cmd_frame_decode.sv
// Testbench for cmd_frame_decode.
// A frame-level reference model predicts every output event: push, write
// trigger, read trigger and error, each tagged with its cycle. It also predicts
// the busy window of every frame. A negedge monitor pops and compares the events
// as the DUT emits them.
module tb_cmd_frame_decode;

  localparam int         LEN  = 4;
  localparam int         TO   = 100;
  localparam logic [7:0] WR   = 8'h55;
  localparam logic [7:0] RD   = 8'hAA;
  localparam int         MAXC = 40000;

  localparam logic [3:0] K_PUSH   = 4'd1;
  localparam logic [3:0] K_WR     = 4'd2;
  localparam logic [3:0] K_RD     = 4'd3;
  localparam logic [3:0] K_ERR    = 4'd4;
  localparam logic [3:0] K_ERRCLR = 4'd5;
  localparam logic [3:0] K_CLR    = 4'd6;

  // Clock and reset.
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_flag = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic       wfifo_full = 1'b0;
  logic       wfifo_wr_en, wfifo_clr, wr_trig, rd_trig, frame_err, busy;
  logic [7:0] wfifo_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cmd_frame_decode #(
    .PAYLOAD_LEN(LEN), .WR_CMD(WR), .RD_CMD(RD), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .uart_flag(uart_flag), .uart_data(uart_data),
    .wfifo_full(wfifo_full), .wfifo_wr_en(wfifo_wr_en), .wfifo_data(wfifo_data),
    .wfifo_clr(wfifo_clr), .wr_trig(wr_trig), .rd_trig(rd_trig),
    .frame_err(frame_err), .busy(busy)
  );

  // Scoreboard state.
  int          total = 0;
  int          bad = 0;
  logic [43:0] exp_q[$];
  bit          busy_exp[MAXC];
  bit          busy_act[MAXC];

  // Reference model: frame-level view of the decoder.
  bit         m_frame = 0;
  bit         m_chk = 0;
  int         m_cnt = 0;
  int         m_last = 0;
  int         m_start = 0;
  logic [7:0] m_xor = 8'h00;

  function automatic void expect_ev(input int c, input logic [3:0] k, input logic [7:0] d);
    exp_q.push_back({c[31:0], k, d});
  endfunction

  // A frame that ends at cycle e has busy set from (start + 1) through (e - 1).
  function automatic void close_frame(input int e);
    for (int i = m_start + 1; i < e; i++) if (i < MAXC) busy_exp[i] = 1'b1;
    m_frame = 0;
    m_chk   = 0;
  endfunction

  // A cycle with no strobe. Timeout fires TO cycles after the last strobe.
  function automatic void model_tick(input int c);
    if (m_frame && (c - m_last >= TO - 1)) begin
      expect_ev(c + 1, K_ERRCLR, 8'h00);
      close_frame(c + 1);
    end
  endfunction

  function automatic void model_byte(input int c, input logic [7:0] b, input bit full);
    if (!m_frame) begin
      if (b == RD) expect_ev(c + 1, K_RD, 8'h00);
      else if (b == WR) begin
        m_frame = 1; m_chk = 0; m_cnt = 0; m_xor = 8'h00; m_start = c; m_last = c;
      end else expect_ev(c + 1, K_ERR, 8'h00);
    end else if (m_chk) begin
      if (b == m_xor) expect_ev(c + 1, K_WR, 8'h00);
      else expect_ev(c + 1, K_ERRCLR, 8'h00);
      close_frame(c + 1);
    end else if (full) begin
      expect_ev(c + 1, K_ERRCLR, 8'h00);
      close_frame(c + 1);
    end else begin
      expect_ev(c + 1, K_PUSH, b);
      m_cnt++;
      m_xor  = m_xor ^ b;
      m_last = c;
      if (m_cnt == LEN) begin
`ifdef CMD_FRAME_CHKSUM_EN
        m_chk = 1;
`else
        expect_ev(c + 2, K_WR, 8'h00);
        close_frame(c + 2);
`endif
      end
    end
  endfunction

  // Driver tasks.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      uart_flag  = 1'b0;
      uart_data  = 8'($urandom_range(0, 255));
      wfifo_full = 1'($urandom_range(0, 1));
      model_tick(cyc);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit full, input int gap);
    @(posedge clk); #1;
    uart_flag  = 1'b1;
    uart_data  = b;
    wfifo_full = full;
    model_byte(cyc, b, full);
    idle(gap);
  endtask

  task automatic wr_frame(input logic [7:0] b0, b1, b2, b3, input int gap);
    send(WR, 0, gap);
    send(b0, 0, gap);
    send(b1, 0, gap);
    send(b2, 0, gap);
    send(b3, 0, gap);
`ifdef CMD_FRAME_CHKSUM_EN
    send(b0 ^ b1 ^ b2 ^ b3, 0, gap);
`endif
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({wfifo_wr_en, wfifo_data, wfifo_clr, wr_trig, rd_trig, frame_err, busy} != 14'd0) begin
      bad++;
      $display("FAIL %s: outputs=%04h expected 0000", name,
               {wfifo_wr_en, wfifo_data, wfifo_clr, wr_trig, rd_trig, frame_err, busy});
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    uart_flag = 1'b0;
    if (m_frame) close_frame(cyc + 1);
    @(posedge clk); #1;
    check_zero("mid_frame_reset");
    rst = 1'b0;
  endtask

  // Monitor: pops one expected event per emitted output event.
  task automatic check_ev(input logic [43:0] act);
    logic [43:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event_unexpected: got cyc=%0d kind=%0d data=%02h, none expected",
               act[43:12], act[11:8], act[7:0]);
    end else begin
      e = exp_q.pop_front();
      if (e != act) begin
        bad++;
        $display("FAIL event: got cyc=%0d kind=%0d data=%02h expected cyc=%0d kind=%0d data=%02h",
                 act[43:12], act[11:8], act[7:0], e[43:12], e[11:8], e[7:0]);
      end
    end
  endtask

  // Collect busy every cycle, check the data-idle rule, and compare output events.
  always @(negedge clk) begin
    if (cyc < MAXC) busy_act[cyc] = busy;
    total++;
    if (!wfifo_wr_en && wfifo_data != 8'h00) begin
      bad++;
      $display("FAIL data_idle: cyc=%0d wfifo_data=%02h expected 00", cyc, wfifo_data);
    end
    if (wfifo_wr_en) check_ev({cyc[31:0], K_PUSH, wfifo_data});
    if (wr_trig) check_ev({cyc[31:0], K_WR, 8'h00});
    if (rd_trig) check_ev({cyc[31:0], K_RD, 8'h00});
    if (frame_err) check_ev({cyc[31:0], wfifo_clr ? K_ERRCLR : K_ERR, 8'h00});
    else if (wfifo_clr) check_ev({cyc[31:0], K_CLR, 8'h00});
  end

  // Stimulus sequence and final report.
  initial begin
    int         r, gap, fails_shown, last_c;
    logic [7:0] b;
    bit         full;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;
    idle(3);

    // Write frame with bytes spaced 10 cycles apart.
    wr_frame(8'h11, 8'h22, 8'h33, 8'h44, 9);
    // Read command.
    send(RD, 0, 9);
    // Unknown command, followed by a normal write frame.
    send(8'h3C, 0, 5);
    wr_frame(8'h01, 8'h02, 8'h03, 8'h04, 4);
    // Timeout after one payload byte, then a read.
    send(WR, 0, 3);
    send(8'h01, 0, TO + 5);
    send(RD, 0, 5);
    // FIFO full on the second payload byte.
    send(WR, 0, 3);
    send(8'h01, 0, 3);
    send(8'h02, 1, 5);
    // Reset in the middle of a frame.
    send(WR, 0, 3);
    send(8'h01, 0, 2);
    do_reset();
    idle(4);
`ifdef CMD_FRAME_CHKSUM_EN
    send(WR, 0, 3); send(8'h01, 0, 3); send(8'h02, 0, 3); send(8'h04, 0, 3);
    send(8'h08, 0, 3); send(8'h0F, 0, 5);
    send(WR, 0, 3); send(8'h01, 0, 3); send(8'h02, 0, 3); send(8'h04, 0, 3);
    send(8'h08, 0, 3); send(8'h0E, 0, 5);
`endif

    // Randomized traffic, including gaps at both sides of the timeout boundary.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) gap = TO - 2;
      else if (r == 1) gap = TO - 1;
      else if (r == 2) gap = TO + 3;
      else gap = $urandom_range(1, 12);
      full = ($urandom_range(0, 15) == 0);
      if (m_chk) begin
        b = ($urandom_range(0, 1) == 0) ? m_xor : 8'($urandom_range(0, 255));
      end else if (!m_frame) begin
        r = $urandom_range(0, 9);
        if (r < 5) b = WR;
        else if (r < 7) b = RD;
        else b = 8'($urandom_range(0, 255));
      end else begin
        b = 8'($urandom_range(0, 255));
      end
      send(b, full, gap);
      if (m_frame && $urandom_range(0, 40) == 0) do_reset();
    end

    idle(TO + 10);
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
    while (exp_q.size() != 0) begin
      logic [43:0] e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL event_missing: expected cyc=%0d kind=%0d data=%02h",
               e[43:12], e[11:8], e[7:0]);
    end

    // Compare the busy window cycle by cycle.
    fails_shown = 0;
    last_c = (cyc < MAXC) ? cyc : MAXC;
    for (int c = 4; c < last_c; c++) begin
      total++;
      if (busy_act[c] != busy_exp[c]) begin
        bad++;
        if (fails_shown < 8) begin
          $display("FAIL busy: cyc=%0d got=%0d expected=%0d", c, busy_act[c], busy_exp[c]);
          fails_shown++;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_frame_decode.md
Name: cmd_frame_decode

Overview:
Parametrised successor to the UART command decoder in the UART-to-SDRAM test path. Takes bytes from uart_rx and parses frames of one command byte plus, for writes, PAYLOAD_LEN payload bytes. Payload goes to the write FIFO and a write or read trigger goes to the SDRAM controller. Adds a configurable frame length, configurable command codes, an inter-byte timeout, FIFO-full protection, error reporting and a FIFO flush on aborted frames.

Parameters:
PAYLOAD_LEN, 4, number of payload bytes per write frame; must be >= 1.
WR_CMD, 8'h55, command byte that starts a write frame.
RD_CMD, 8'hAA, command byte that requests a read; the frame is 1 byte only.
TIMEOUT_CYC, 50000, clk cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
uart_flag  in  1  one-cycle strobe; uart_data is valid in this cycle.
uart_data  in  8  received byte.
wfifo_full  in  1  write FIFO full flag.
wfifo_wr_en  out  1  write FIFO push strobe.
wfifo_data  out  8  byte to push; 0 whenever wfifo_wr_en=0.
wfifo_clr  out  1  one-cycle flush request to the write FIFO after an aborted write frame.
wr_trig  out  1  one-cycle pulse: a complete write payload is in the FIFO.
rd_trig  out  1  one-cycle pulse: read requested.
frame_err  out  1  one-cycle pulse: unknown command, timeout, overflow, or checksum failure.
busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE; byte counter = 0; timeout counter = 0.
  - All outputs are 0.
  - Reset mid-frame discards the frame silently; no wfifo_clr or frame_err is issued.
- States:
  - IDLE: waiting for a command byte.
  - WR_DATA: receiving payload bytes.
  - CHK: receiving the checksum byte; exists only when the optional feature is compiled in.
- IDLE transitions:
  - uart_flag with RD_CMD at cycle N: rd_trig=1 at N+1; stay in IDLE.
  - uart_flag with WR_CMD at N: go to WR_DATA; byte counter = 0.
  - uart_flag with any other byte at N: frame_err=1 at N+1; stay in IDLE.
  - The command byte is never written to the FIFO.
- WR_DATA, on uart_flag at N with wfifo_full=0:
  - wfifo_wr_en=1 and wfifo_data=uart_data at N+1. All outputs are registered, so latency is 1 cycle.
  - The byte counter increments. Its width is $clog2(PAYLOAD_LEN+1).
- WR_DATA, last payload byte (counter == PAYLOAD_LEN-1) at N:
  - Its push occurs at N+1.
  - wr_trig=1 at N+2, then return to IDLE. The trigger never precedes the last FIFO push.
- WR_DATA, uart_flag at N with wfifo_full=1:
  - The byte is not pushed.
  - frame_err=1 and wfifo_clr=1 at N+1; return to IDLE.
- Timeout (WR_DATA/CHK only, TIMEOUT_CYC>0):
  - The timeout counter clears on every uart_flag and on entry to the state.
  - If TIMEOUT_CYC consecutive cycles pass without uart_flag, frame_err=1 and wfifo_clr=1 for one cycle; return to IDLE.
  - If uart_flag and timeout expiry fall in the same cycle, the byte wins: it is accepted and the counter clears.
  - There is no timeout in IDLE.
- A byte equal to WR_CMD or RD_CMD inside WR_DATA is treated as payload; no resync.
- Pulses never overlap:
  - wr_trig, rd_trig and frame_err are mutually exclusive.
  - wfifo_clr coincides only with frame_err.
- busy is registered: 1 from the cycle after WR_CMD is accepted until the cycle wr_trig or frame_err is asserted (inclusive of neither).

Optional Feature:
Macro CMD_FRAME_CHKSUM_EN.
- Defined:
  - After the last payload byte, go to CHK instead of issuing wr_trig.
  - The next byte is compared with the XOR of all PAYLOAD_LEN payload bytes.
  - Match at N: wr_trig=1 at N+1.
  - Mismatch at N: frame_err=1 and wfifo_clr=1 at N+1.
  - Either way, return to IDLE.
  - The checksum byte is never pushed to the FIFO.
  - The timeout applies in CHK.
- Not defined: no CHK state and no XOR register; wr_trig follows the last payload byte as in Behaviour.

Test Plan:
- Byte stream 55,11,22,33,44 spaced 10 cycles apart (TIMEOUT_CYC=50000) -> four pushes 11,22,33,44, then one wr_trig 1 cycle after the push of 44; no frame_err.
- Byte AA in IDLE -> rd_trig pulse 1 cycle later; no FIFO push; busy stays 0.
- Byte 3C in IDLE -> frame_err pulse only; then 55,01,02,03,04 completes normally.
- TIMEOUT_CYC=100; send 55,01 then silence -> frame_err and wfifo_clr pulse exactly 100 cycles after the 01 strobe; next byte AA yields rd_trig.
- 55,01 then wfifo_full=1 during 02 -> no push of 02; frame_err and wfifo_clr at N+1; rst asserted mid-frame on a separate run -> all outputs 0, no pulses.
- With CMD_FRAME_CHKSUM_EN: 55,01,02,04,08,0F -> wr_trig; 55,01,02,04,08,0E -> frame_err and wfifo_clr, no wr_trig.
